cu_lsu: RTL and testbench

Load/store initiator inside the CU. It drives the CU-side request interface of the MMU.
- Takes one RV32I load/store per request, computes the effective address and checks alignment and funct3 legality.
- Builds byte enables and lane-replicated store data, then issues a single `retrieve` pulse.
- Waits for `mmu_complete`, then returns sign- or zero-extended load data to the execute stage.
- Bounds every wait with a timeout.

---
 rtl/cu_lsu_pkg.sv | 25 ++
 rtl/cu_lsu_if.sv | 34 +++
 rtl/cu_lsu_align.sv | 65 ++++++
 rtl/cu_lsu.sv | 147 ++++++++++++++
 tb/tb_cu_lsu.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_lsu_pkg.sv
// Shared types for the CU load/store initiator.
// Funct3 encodings, FSM states and fault causes.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_ILLEGAL  = 2'b10,
        FC_TIMEOUT  = 2'b11
    } lsu_fault_t;

endpackage

// File: rtl/cu_lsu_if.sv
// CU-side request bus towards the MMU.
// master = load/store unit, slave = MMU.
interface cu_lsu_if;
    import lsu_pkg::*;

    logic [31:0] CU_address;
    logic [3:0]  CU_bytesel;
    logic [31:0] CU_dat_in;
    logic        read_or_write;
    logic        retrieve;
    logic [31:0] CU_dat_out;
    logic        mmu_complete;

    modport master (
        output CU_address,
        output CU_bytesel,
        output CU_dat_in,
        output read_or_write,
        output retrieve,
        input  CU_dat_out,
        input  mmu_complete
    );

    modport slave (
        input  CU_address,
        input  CU_bytesel,
        input  CU_dat_in,
        input  read_or_write,
        input  retrieve,
        output CU_dat_out,
        output mmu_complete
    );

endinterface

// File: rtl/cu_lsu_align.sv
// Lane logic: byte enables, store replication,
// load extension and legality flags.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  bytesel,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misaligned,
    output logic        illegal
);

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic [31:0] lane;

    always_comb begin
        is_b = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h = (funct3 == F3_H) || (funct3 == F3_HU);
        is_w = (funct3 == F3_W);
        // Stores have no unsigned forms.
        illegal = !(is_b || is_h || is_w)
                || (is_store && funct3[2]);
        misaligned = (is_h && ea_lo[0])
                   || (is_w && (ea_lo != 2'b00));
        lane = rdata >> {ea_lo, 3'b000};
        bytesel = 4'b0000;
        wdata = 32'h0;
        ldata = 32'h0;
        unique case (1'b1)
            is_b: begin
                bytesel = 4'b0001 << ea_lo;
                wdata = {4{store_data[7:0]}};
                ldata = funct3[2]
                      ? {24'h0, lane[7:0]}
                      : {{24{lane[7]}}, lane[7:0]};
            end
            is_h: begin
                bytesel = ea_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
                ldata = funct3[2]
                      ? {16'h0, lane[15:0]}
                      : {{16{lane[15]}}, lane[15:0]};
            end
            is_w: begin
                bytesel = 4'b1111;
                wdata = store_data;
                ldata = rdata;
            end
            default: begin
                bytesel = 4'b0000;
            end
        endcase
        if (!is_store) begin
            wdata = 32'h0;
        end
    end

endmodule

// File: rtl/cu_lsu.sv
// CU load/store initiator: decode, single MMU
// request, bounded wait and load-data return.
module cu_lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        soc_clk,
    input  logic        soc_rst,
    input  logic        lsu_start,
    input  logic        lsu_is_store,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_base,
    input  logic [31:0] lsu_offset,
    input  logic [31:0] lsu_store_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_load_data,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_cause,
    cu_lsu_if.master    mmu
);

    lsu_state_t      state;
    logic [TO_W-1:0] cnt;
    logic [2:0]      f3_q;
    logic            st_q;
    logic [1:0]      ea_lo_q;

    logic [31:0] ea;
    logic        idle;
    logic [2:0]  al_f3;
    logic        al_st;
    logic [1:0]  al_ea;
    logic [3:0]  al_bsel;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_mis;
    logic        al_ill;

    assign ea = lsu_base + lsu_offset;
    assign idle = (state == IDLE);
    assign lsu_busy = !idle;

    // Decode from live inputs in IDLE, from latches after.
    assign al_f3 = idle ? lsu_funct3 : f3_q;
    assign al_st = idle ? lsu_is_store : st_q;
    assign al_ea = idle ? ea[1:0] : ea_lo_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .is_store   (al_st),
        .ea_lo      (al_ea),
        .store_data (lsu_store_data),
        .rdata      (mmu.CU_dat_out),
        .bytesel    (al_bsel),
        .wdata      (al_wdata),
        .ldata      (al_ldata),
        .misaligned (al_mis),
        .illegal    (al_ill)
    );

    always_ff @(posedge soc_clk or posedge soc_rst) begin
        if (soc_rst) begin
            state <= IDLE;
            cnt <= '0;
            f3_q <= 3'b000;
            st_q <= 1'b0;
            ea_lo_q <= 2'b00;
            lsu_done <= 1'b0;
            lsu_load_data <= 32'h0;
            lsu_fault <= 1'b0;
            lsu_fault_cause <= FC_NONE;
            mmu.CU_address <= 32'h0;
            mmu.CU_bytesel <= 4'b0000;
            mmu.CU_dat_in <= 32'h0;
            mmu.read_or_write <= 1'b0;
            mmu.retrieve <= 1'b0;
        end else begin
            lsu_done <= 1'b0;
            lsu_fault <= 1'b0;
            lsu_fault_cause <= FC_NONE;
            mmu.retrieve <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (lsu_start) begin
                        f3_q <= lsu_funct3;
                        st_q <= lsu_is_store;
                        ea_lo_q <= ea[1:0];
                        if (al_ill || al_mis) begin
                            state <= DONE;
                            lsu_done <= 1'b1;
                            lsu_fault <= 1'b1;
                            lsu_fault_cause <= al_ill
                                ? FC_ILLEGAL : FC_MISALIGN;
                            lsu_load_data <= 32'h0;
                        end else begin
                            state <= ISSUE;
                            mmu.retrieve <= 1'b1;
                            mmu.CU_address <= {ea[31:2], 2'b00};
                            mmu.CU_bytesel <= al_bsel;
                            mmu.CU_dat_in <= al_wdata;
                            mmu.read_or_write <= lsu_is_store;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt <= '0;
                end
                WAIT: begin
                    // Completion wins over a coincident timeout.
                    if (mmu.mmu_complete) begin
                        state <= DONE;
                        lsu_done <= 1'b1;
                        lsu_load_data <= st_q ? 32'h0 : al_ldata;
                        mmu.CU_address <= 32'h0;
                        mmu.CU_bytesel <= 4'b0000;
                        mmu.CU_dat_in <= 32'h0;
                        mmu.read_or_write <= 1'b0;
                    end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state <= DONE;
                        lsu_done <= 1'b1;
                        lsu_fault <= 1'b1;
                        lsu_fault_cause <= FC_TIMEOUT;
                        lsu_load_data <= 32'h0;
                        mmu.CU_address <= 32'h0;
                        mmu.CU_bytesel <= 4'b0000;
                        mmu.CU_dat_in <= 32'h0;
                        mmu.read_or_write <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_lsu.sv
// Directed bench for cu_lsu with a transaction-level
// reference model and a per-cycle compare process.
module tb_cu_lsu;
    import lsu_pkg::*;

    localparam int TO = 8;

    logic        soc_clk;
    logic        soc_rst;
    logic        lsu_start;
    logic        lsu_is_store;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_base;
    logic [31:0] lsu_offset;
    logic [31:0] lsu_store_data;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_load_data;
    logic        lsu_fault;
    logic [1:0]  lsu_fault_cause;

    cu_lsu_if bus ();

    cu_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .soc_clk         (soc_clk),
        .soc_rst         (soc_rst),
        .lsu_start       (lsu_start),
        .lsu_is_store    (lsu_is_store),
        .lsu_funct3      (lsu_funct3),
        .lsu_base        (lsu_base),
        .lsu_offset      (lsu_offset),
        .lsu_store_data  (lsu_store_data),
        .lsu_busy        (lsu_busy),
        .lsu_done        (lsu_done),
        .lsu_load_data   (lsu_load_data),
        .lsu_fault       (lsu_fault),
        .lsu_fault_cause (lsu_fault_cause),
        .mmu             (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;
    always @(posedge soc_clk) cyc = cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference model: one outstanding transaction.
    bit          act = 1'b0;
    int          t0 = 0;
    int          tdone = 0;
    bit          e_dfault = 1'b0;
    bit          e_fault = 1'b0;
    logic [1:0]  e_cause = 2'b00;
    logic [31:0] e_addr = 32'h0;
    logic [3:0]  e_bsel = 4'h0;
    logic [31:0] e_din = 32'h0;
    bit          e_rw = 1'b0;
    logic [31:0] e_ld = 32'h0;
    logic [31:0] e_ld_next = 32'h0;

    task automatic model_start(input bit st,
                               input logic [2:0] f3,
                               input logic [31:0] base,
                               input logic [31:0] off,
                               input logic [31:0] sd,
                               input int lat,
                               input logic [31:0] rd,
                               input int t);
        logic [31:0] ea, lane, mask, v;
        int size, m;
        bit legal;
        ea = base + off;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2)
                   : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        act = 1'b1;
        t0 = t;
        e_rw = st;
        e_addr = ea & 32'hFFFF_FFFC;
        m = ((1 << size) - 1) << ea[1:0];
        e_bsel = m[3:0];
        e_din = 32'h0;
        if (st) begin
            for (int i = 0; i < 4; i++)
                e_din[8*i +: 8] = sd[8*(i % size) +: 8];
        end
        lane = rd >> (8 * ea[1:0]);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
        v = lane & mask;
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
        e_dfault = 1'b1;
        e_fault = 1'b1;
        if (!legal) begin
            e_cause = 2'b10;
            tdone = t;
        end else if ((ea % size) != 0) begin
            e_cause = 2'b01;
            tdone = t;
        end else if (lat < 0 || lat > TO) begin
            e_dfault = 1'b0;
            e_cause = 2'b11;
            tdone = t + 1 + TO;
        end else begin
            e_dfault = 1'b0;
            e_fault = 1'b0;
            e_cause = 2'b00;
            tdone = t + 1 + lat;
        end
        e_ld_next = (e_fault || st) ? 32'h0 : v;
    endtask

    task automatic model_reset();
        act = 1'b0;
        e_ld = 32'h0;
    endtask

    always @(negedge soc_clk) begin : cmp
        bit b, r, d;
        if (!soc_rst) begin
            b = act && cyc >= t0 && cyc <= tdone;
            r = act && !e_dfault && cyc == t0;
            d = act && cyc == tdone;
            if (d) e_ld = e_ld_next;
            check("busy", lsu_busy, b);
            check("retrieve", bus.retrieve, r);
            check("done", lsu_done, d);
            check("fault", lsu_fault, d ? e_fault : 1'b0);
            check("cause", lsu_fault_cause, d ? e_cause : 2'b00);
            check("load_data", lsu_load_data, e_ld);
            if (act && !e_dfault && cyc >= t0 && cyc < tdone) begin
                check("address", bus.CU_address, e_addr);
                check("bytesel", bus.CU_bytesel, e_bsel);
                check("dat_in", bus.CU_dat_in, e_din);
                check("rw", bus.read_or_write, e_rw);
            end
        end
    end

    // One request; l_dly is the done cycle relative to start (T+n).
    task automatic run_op(input bit st,
                          input logic [2:0] f3,
                          input logic [31:0] base,
                          input logic [31:0] off,
                          input logic [31:0] sd,
                          input int lat,
                          input logic [31:0] rd,
                          input logic [31:0] l_addr,
                          input logic [3:0] l_bsel,
                          input logic [31:0] l_din,
                          input logic [31:0] l_ld,
                          input logic [1:0] l_cause,
                          input int l_dly);
        int t, nd, dly;
        logic [1:0] cs;
        nd = 0;
        dly = -1;
        cs = 2'b00;
        @(negedge soc_clk);
        model_start(st, f3, base, off, sd, lat, rd, cyc + 1);
        lsu_start = 1'b1;
        lsu_is_store = st;
        lsu_funct3 = f3;
        lsu_base = base;
        lsu_offset = off;
        lsu_store_data = sd;
        @(posedge soc_clk);
        #1;
        lsu_start = 1'b0;
        t = cyc;
        for (int i = 0; i < 20; i++) begin
            if (lat >= 0 && cyc == t + lat) begin
                bus.mmu_complete = 1'b1;
                bus.CU_dat_out = rd;
            end else if (lat < 0 && cyc >= t + TO + 1
                         && cyc <= t + TO + 3) begin
                bus.mmu_complete = 1'b1;
                bus.CU_dat_out = 32'h5A5A_5A5A;
            end else begin
                bus.mmu_complete = 1'b0;
                bus.CU_dat_out = 32'hDEAD_BEEF;
            end
            @(negedge soc_clk);
            if (cyc == t && l_bsel != 4'h0) begin
                check("lit_retrieve", bus.retrieve, 1'b1);
                check("lit_addr", bus.CU_address, l_addr);
                check("lit_bsel", bus.CU_bytesel, l_bsel);
                check("lit_din", bus.CU_dat_in, l_din);
            end
            if (lsu_done) begin
                nd++;
                dly = cyc - t + 1;
                cs = lsu_fault_cause;
            end
            @(posedge soc_clk);
            #1;
        end
        bus.mmu_complete = 1'b0;
        check("lit_ndone", nd, 1);
        check("lit_latency", dly, l_dly);
        check("lit_cause", cs, l_cause);
        check("lit_ld", lsu_load_data, l_ld);
    endtask

    initial begin : stim
        int t;
        soc_rst = 1'b1;
        lsu_start = 1'b0;
        lsu_is_store = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_base = 32'h0;
        lsu_offset = 32'h0;
        lsu_store_data = 32'h0;
        bus.mmu_complete = 1'b0;
        bus.CU_dat_out = 32'h0;
        repeat (3) @(posedge soc_clk);
        #1;
        check("rst_busy", lsu_busy, 1'b0);
        check("rst_done", lsu_done, 1'b0);
        check("rst_ld", lsu_load_data, 32'h0);
        check("rst_fault", lsu_fault, 1'b0);
        check("rst_cause", lsu_fault_cause, 2'b00);
        check("rst_retrieve", bus.retrieve, 1'b0);
        check("rst_addr", bus.CU_address, 32'h0);
        check("rst_bsel", bus.CU_bytesel, 4'h0);
        check("rst_din", bus.CU_dat_in, 32'h0);
        check("rst_rw", bus.read_or_write, 1'b0);
        @(negedge soc_clk);
        soc_rst = 1'b0;

        // LB, LHU, LH, SH, SB, LBU, LW at timeout edge, SW
        run_op(0, F3_B, 32'h100, 32'h3, 32'h0, 2, 32'h80FF_1234,
               32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00, 4);
        run_op(0, F3_HU, 32'h1FE, 32'h0, 32'h0, 1, 32'hBEEF_0000,
               32'h1FC, 4'b1100, 32'h0, 32'h0000_BEEF, 2'b00, 3);
        run_op(0, F3_H, 32'h1FE, 32'h0, 32'h0, 1, 32'hBEEF_0000,
               32'h1FC, 4'b1100, 32'h0, 32'hFFFF_BEEF, 2'b00, 3);
        run_op(1, F3_H, 32'h40, 32'h2, 32'h1234_ABCD, 1, 32'h0,
               32'h40, 4'b1100, 32'hABCD_ABCD, 32'h0, 2'b00, 3);
        run_op(1, F3_B, 32'h205, 32'hFFFF_FFFC, 32'h0000_00A5, 3, 32'h0,
               32'h200, 4'b0010, 32'hA5A5_A5A5, 32'h0, 2'b00, 5);
        run_op(0, F3_BU, 32'h200, 32'h2, 32'h0, 1, 32'h00C3_0000,
               32'h200, 4'b0100, 32'h0, 32'h0000_00C3, 2'b00, 3);
        run_op(0, F3_W, 32'hFFFF_FFF0, 32'h20, 32'h0, TO, 32'h1357_9BDF,
               32'h10, 4'b1111, 32'h0, 32'h1357_9BDF, 2'b00, 10);
        run_op(1, F3_W, 32'h300, 32'h4, 32'hCAFE_F00D, 1, 32'h0,
               32'h304, 4'b1111, 32'hCAFE_F00D, 32'h0, 2'b00, 3);

        // Decode faults: misaligned, illegal, illegal beats misaligned
        run_op(0, F3_W, 32'h100, 32'h1, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1);
        run_op(0, F3_H, 32'h100, 32'h3, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0, 2'b01, 1);
        run_op(1, 3'b100, 32'h40, 32'h0, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1);
        run_op(0, 3'b011, 32'h40, 32'h0, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1);
        run_op(1, 3'b110, 32'h41, 32'h0, 32'h0, -1, 32'h0,
               32'h0, 4'h0, 32'h0, 32'h0, 2'b10, 1);

        // Timeout, followed by ignored late completions
        run_op(0, F3_W, 32'h80, 32'h0, 32'h0, -1, 32'h0,
               32'h80, 4'b1111, 32'h0, 32'h0, 2'b11, 10);

        // Reset during WAIT with lsu_start held high
        @(negedge soc_clk);
        model_start(0, F3_W, 32'h500, 32'h0, 32'h0, -1, 32'h0, cyc + 1);
        lsu_start = 1'b1;
        lsu_is_store = 1'b0;
        lsu_funct3 = F3_W;
        lsu_base = 32'h500;
        lsu_offset = 32'h0;
        @(posedge soc_clk);
        #1;
        t = cyc;
        lsu_funct3 = F3_B;
        lsu_base = 32'h600;
        repeat (3) @(posedge soc_clk);
        @(negedge soc_clk);
        lsu_start = 1'b0;
        check("wait_addr", bus.CU_address, 32'h500);
        #2;
        soc_rst = 1'b1;
        model_reset();
        #1;
        check("arst_busy", lsu_busy, 1'b0);
        check("arst_retrieve", bus.retrieve, 1'b0);
        check("arst_addr", bus.CU_address, 32'h0);
        check("arst_bsel", bus.CU_bytesel, 4'h0);
        check("arst_rw", bus.read_or_write, 1'b0);
        bus.mmu_complete = 1'b1;
        repeat (2) @(negedge soc_clk);
        soc_rst = 1'b0;
        repeat (2) @(negedge soc_clk);
        bus.mmu_complete = 1'b0;
        check("late_cmp_done", lsu_done, 1'b0);
        check("reset_wait_t", (cyc > t) ? 1 : 0, 1);

        run_op(1, F3_W, 32'h700, 32'h0, 32'h1122_3344, 2, 32'h0,
               32'h700, 4'b1111, 32'h1122_3344, 32'h0, 2'b00, 4);

        repeat (3) @(negedge soc_clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
